laser_host: RTL and testbench

Host-side sequencer for the LASER circle-placement engine. It holds up to NSETS point sets of 40 (X,Y) points, resets the engine, and streams each set at one point per cycle. It then waits for the engine's DONE pulse and captures the two circle centres. Optionally it scores the result (points covered by either radius-4 circle) and hands it upstream on a valid/ready port.

---
 rtl/laser_host.sv | 221 ++++++++++++++++++++++
 tb/tb_laser_host.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/laser_host.sv
// laser_host: host-side sequencer for the LASER circle-placement engine.
// Holds NSETS sets of NPTS (X,Y) points. For each set it pulses the engine
// reset, streams one point per cycle, waits for DONE (or a timeout), captures
// the two circle centres and presents them upstream on a valid/ready port.
// Build option: define LASER_HOST_SCORE_EN to compile in the coverage scorer
// (points within radius 4 of either centre); otherwise res_cover is 0.
module laser_host #(
  parameter int NPTS    = 40,
  parameter int NSETS   = 4,
  parameter int TIMEOUT = 65535
) (
  input  logic                     CLK,
  input  logic                     RST,
  input  logic                     ld_valid,
  input  logic [$clog2(NSETS)-1:0] ld_set,
  input  logic [5:0]               ld_idx,
  input  logic [3:0]               ld_x,
  input  logic [3:0]               ld_y,
  input  logic                     start,
  input  logic [$clog2(NSETS)-1:0] start_last,
  output logic                     busy,
  output logic                     eng_rst,
  output logic [3:0]               X,
  output logic [3:0]               Y,
  input  logic                     DONE,
  input  logic [3:0]               C1X,
  input  logic [3:0]               C1Y,
  input  logic [3:0]               C2X,
  input  logic [3:0]               C2Y,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [$clog2(NSETS)-1:0] res_set,
  output logic [3:0]               res_c1x,
  output logic [3:0]               res_c1y,
  output logic [3:0]               res_c2x,
  output logic [3:0]               res_c2y,
  output logic [5:0]               res_cover,
  output logic                     res_err
);

  localparam int          SW       = $clog2(NSETS);
  localparam logic [5:0]  LAST_IDX = 6'(NPTS - 1);
  localparam logic [5:0]  NPTS_W   = 6'(NPTS);
  localparam logic [15:0] TO       = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ERST,
    S_FEED,
    S_WAIT,
    S_SCORE,
    S_REPORT
  } state_t;

  state_t          state;
  logic [SW-1:0]   set;
  logic [SW-1:0]   last;
  logic [5:0]      idx;
  logic [15:0]     cnt;

  // Point memory; deliberately not reset so a reload is not needed after RST.
  logic [3:0] mem_x [NSETS][64];
  logic [3:0] mem_y [NSETS][64];
  logic [3:0] cur_x;
  logic [3:0] cur_y;

  // Load port: accepted only while idle and for in-range indices.
  always_ff @(posedge CLK) begin
    if (ld_valid && !busy && (ld_idx < NPTS_W)) begin
      mem_x[ld_set][ld_idx] <= ld_x;
      mem_y[ld_set][ld_idx] <= ld_y;
    end
  end

  // Current point of the active set, shared by the feeder and the scorer.
  always_comb begin
    cur_x = mem_x[set][idx];
    cur_y = mem_y[set][idx];
  end

  // Engine-facing outputs: point stream only during FEED, reset pulse in ERST.
  always_comb begin
    X       = '0;
    Y       = '0;
    eng_rst = RST || (state == S_ERST);
    if (state == S_FEED) begin
      X = cur_x;
      Y = cur_y;
    end
  end

  assign res_set = set;

`ifdef LASER_HOST_SCORE_EN
  logic [5:0] cover_q;
  logic       hit;

  function automatic logic [8:0] dist2(input logic [3:0] px, input logic [3:0] py,
                                       input logic [3:0] cx, input logic [3:0] cy);
    logic [8:0] dx;
    logic [8:0] dy;
    dx = {5'b0, ((px >= cx) ? (px - cx) : (cx - px))};
    dy = {5'b0, ((py >= cy) ? (py - cy) : (cy - py))};
    return (dx * dx) + (dy * dy);
  endfunction

  // A point is covered when it lies within radius 4 of either captured centre.
  always_comb begin
    hit = (dist2(cur_x, cur_y, res_c1x, res_c1y) <= 9'd16) ||
          (dist2(cur_x, cur_y, res_c2x, res_c2y) <= 9'd16);
  end

  assign res_cover = cover_q;
`else
  assign res_cover = '0;
`endif

  // Sequencer: one run walks sets 0..last through ERST/FEED/WAIT/(SCORE)/REPORT.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= S_IDLE;
      set       <= '0;
      last      <= '0;
      idx       <= '0;
      cnt       <= '0;
      busy      <= 1'b0;
      res_valid <= 1'b0;
      res_c1x   <= '0;
      res_c1y   <= '0;
      res_c2x   <= '0;
      res_c2y   <= '0;
      res_err   <= 1'b0;
`ifdef LASER_HOST_SCORE_EN
      cover_q   <= '0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            set   <= '0;
            last  <= start_last;
            busy  <= 1'b1;
            state <= S_ERST;
          end
        end
        S_ERST: begin
          idx   <= '0;
          state <= S_FEED;
        end
        S_FEED: begin
          if (idx == LAST_IDX) begin
            cnt   <= '0;
            state <= S_WAIT;
          end else begin
            idx <= idx + 6'd1;
          end
        end
        S_WAIT: begin
          // DONE takes priority over a timeout expiring in the same cycle.
          if (DONE) begin
            res_c1x <= C1X;
            res_c1y <= C1Y;
            res_c2x <= C2X;
            res_c2y <= C2Y;
            res_err <= 1'b0;
`ifdef LASER_HOST_SCORE_EN
            cover_q <= '0;
            idx     <= '0;
            state   <= S_SCORE;
`else
            res_valid <= 1'b1;
            state     <= S_REPORT;
`endif
          end else if (cnt == TO) begin
            res_c1x   <= '0;
            res_c1y   <= '0;
            res_c2x   <= '0;
            res_c2y   <= '0;
            res_err   <= 1'b1;
            res_valid <= 1'b1;
`ifdef LASER_HOST_SCORE_EN
            cover_q   <= '0;
`endif
            state     <= S_REPORT;
          end else begin
            cnt <= cnt + 16'd1;
          end
        end
`ifdef LASER_HOST_SCORE_EN
        S_SCORE: begin
          if (hit) begin
            cover_q <= cover_q + 6'd1;
          end
          if (idx == LAST_IDX) begin
            res_valid <= 1'b1;
            state     <= S_REPORT;
          end else begin
            idx <= idx + 6'd1;
          end
        end
`endif
        S_REPORT: begin
          if (res_ready) begin
            res_valid <= 1'b0;
            if (set == last) begin
              busy  <= 1'b0;
              state <= S_IDLE;
            end else begin
              set   <= set + SW'(1);
              state <= S_ERST;
            end
          end
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_laser_host.sv
// tb_laser_host: directed self-checking bench for laser_host.
// Covers reset values, feed timing, DONE capture, back-pressure over several
// sets, timeout and DONE-at-timeout, coverage boundaries, misuse while busy
// and reset in the middle of a feed.
module tb_laser_host;

`ifdef LASER_HOST_SCORE_EN
  localparam int SCORE_LAT = 40;
`else
  localparam int SCORE_LAT = 0;
`endif

  logic       CLK;
  logic       RST;
  logic       ld_valid;
  logic [1:0] ld_set;
  logic [5:0] ld_idx;
  logic [3:0] ld_x;
  logic [3:0] ld_y;
  logic       start;
  logic [1:0] start_last;
  logic       busy;
  logic       eng_rst;
  logic [3:0] X;
  logic [3:0] Y;
  logic       DONE;
  logic [3:0] C1X;
  logic [3:0] C1Y;
  logic [3:0] C2X;
  logic [3:0] C2Y;
  logic       res_valid;
  logic       res_ready;
  logic [1:0] res_set;
  logic [3:0] res_c1x;
  logic [3:0] res_c1y;
  logic [3:0] res_c2x;
  logic [3:0] res_c2y;
  logic [5:0] res_cover;
  logic       res_err;

  int n_chk;
  int n_fail;

  laser_host #(.NPTS(40), .NSETS(4), .TIMEOUT(100)) dut (
    .CLK(CLK), .RST(RST),
    .ld_valid(ld_valid), .ld_set(ld_set), .ld_idx(ld_idx), .ld_x(ld_x), .ld_y(ld_y),
    .start(start), .start_last(start_last), .busy(busy), .eng_rst(eng_rst),
    .X(X), .Y(Y), .DONE(DONE), .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
    .res_valid(res_valid), .res_ready(res_ready), .res_set(res_set),
    .res_c1x(res_c1x), .res_c1y(res_c1y), .res_c2x(res_c2x), .res_c2y(res_c2y),
    .res_cover(res_cover), .res_err(res_err)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // Reference point sets, hand-chosen so coverage counts are easy to derive.
  function automatic logic [3:0] px(input int s, input int i);
    case (s)
      0:       return (i < 20) ? 4'(3 + i % 3) : 4'd12;
      1:       return (i < 10) ? 4'd7 : (i < 30) ? 4'd8 : 4'd3;
      2:       return (i < 30) ? 4'd15 : 4'd8;
      default: return 4'(i % 16);
    endcase
  endfunction

  function automatic logic [3:0] py(input int s, input int i);
    case (s)
      0:       return (i < 20) ? 4'd3 : 4'(12 - i % 3);
      1:       return (i < 30) ? 4'd3 : 4'd7;
      2:       return (i < 30) ? 4'd0 : 4'd8;
      default: return 4'(15 - i % 16);
    endcase
  endfunction

  function automatic logic [5:0] exp_cov(input int n);
    return (SCORE_LAT != 0) ? 6'(n) : 6'd0;
  endfunction

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Entered in the ERST cycle; leaves in the first WAIT_DONE cycle.
  task automatic run_feed(input int s, input bit misuse);
    chk("erst_pulse", 32'(eng_rst), 1);
    chk("erst_busy", 32'(busy), 1);
    chk("erst_set", 32'(res_set), 32'(s));
    chk("erst_valid", 32'(res_valid), 0);
    tick();
    for (int i = 0; i < 40; i++) begin
      if (misuse && i == 2) begin
        ld_valid = 1'b1; ld_set = 2'd0; ld_idx = 6'd39; ld_x = 4'd15; ld_y = 4'd15;
        start = 1'b1; start_last = 2'd0;
      end
      if (misuse && i == 3) begin
        ld_valid = 1'b0; start = 1'b0; start_last = 2'd2;
      end
      chk("feed_x", 32'(X), 32'(px(s, i)));
      chk("feed_y", 32'(Y), 32'(py(s, i)));
      chk("feed_rst", 32'(eng_rst), 0);
      tick();
    end
    chk("wait_x", 32'(X), 0);
    chk("wait_y", 32'(Y), 0);
  endtask

  // Entered in the cycle DONE is driven; leaves in the first REPORT cycle.
  task automatic finish_set(input int s, input logic [3:0] a, input logic [3:0] b,
                            input logic [3:0] c, input logic [3:0] d, input int cov);
    DONE = 1'b1; C1X = a; C1Y = b; C2X = c; C2Y = d;
    tick();
    DONE = 1'b0; C1X = '0; C1Y = '0; C2X = '0; C2Y = '0;
    for (int k = 0; k < SCORE_LAT; k++) begin
      chk("score_valid", 32'(res_valid), 0);
      tick();
    end
    chk("rep_valid", 32'(res_valid), 1);
    chk("rep_set", 32'(res_set), 32'(s));
    chk("rep_c1x", 32'(res_c1x), 32'(a));
    chk("rep_c1y", 32'(res_c1y), 32'(b));
    chk("rep_c2x", 32'(res_c2x), 32'(c));
    chk("rep_c2y", 32'(res_c2y), 32'(d));
    chk("rep_cover", 32'(res_cover), 32'(exp_cov(cov)));
    chk("rep_err", 32'(res_err), 0);
    chk("rep_busy", 32'(busy), 1);
  endtask

  task automatic accept();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
  endtask

  task automatic do_start(input logic [1:0] lst);
    start = 1'b1; start_last = lst;
    chk("start_idle_rst", 32'(eng_rst), 0);
    tick();
    start = 1'b0;
  endtask

  initial begin
    n_chk = 0; n_fail = 0;
    RST = 1'b1; ld_valid = 1'b0; ld_set = '0; ld_idx = '0; ld_x = '0; ld_y = '0;
    start = 1'b0; start_last = '0; DONE = 1'b0;
    C1X = '0; C1Y = '0; C2X = '0; C2Y = '0; res_ready = 1'b0;
    repeat (3) tick();

    // Reset state
    chk("rst_busy", 32'(busy), 0);
    chk("rst_eng", 32'(eng_rst), 1);
    chk("rst_x", 32'(X), 0);
    chk("rst_valid", 32'(res_valid), 0);
    chk("rst_set", 32'(res_set), 0);
    chk("rst_c1x", 32'(res_c1x), 0);
    chk("rst_cover", 32'(res_cover), 0);
    chk("rst_err", 32'(res_err), 0);
    RST = 1'b0;
    tick();
    chk("post_rst_eng", 32'(eng_rst), 0);

    // Preload all sets
    for (int s = 0; s < 4; s++) begin
      for (int i = 0; i < 40; i++) begin
        ld_valid = 1'b1; ld_set = 2'(s); ld_idx = 6'(i); ld_x = px(s, i); ld_y = py(s, i);
        tick();
      end
    end
    ld_valid = 1'b0;

    // Single set, centres found
    do_start(2'd0);
    run_feed(0, 1'b0);
    finish_set(0, 4'd3, 4'd3, 4'd12, 4'd12, 40);
    accept();
    chk("single_busy_fall", 32'(busy), 0);
    chk("single_valid_fall", 32'(res_valid), 0);

    // Multi-set with back-pressure and misuse during the first feed
    do_start(2'd2);
    run_feed(0, 1'b1);
    finish_set(0, 4'd3, 4'd3, 4'd12, 4'd12, 40);
    for (int k = 0; k < 20; k++) begin
      DONE = 1'b1; C1X = 4'd9; C1Y = 4'd9; C2X = 4'd1; C2Y = 4'd1;
      chk("bp_valid", 32'(res_valid), 1);
      chk("bp_c1x", 32'(res_c1x), 3);
      chk("bp_c2y", 32'(res_c2y), 12);
      chk("bp_set", 32'(res_set), 0);
      chk("bp_rst", 32'(eng_rst), 0);
      tick();
    end
    DONE = 1'b0; C1X = '0; C1Y = '0; C2X = '0; C2Y = '0;
    accept();
    run_feed(1, 1'b0);
    finish_set(1, 4'd3, 4'd3, 4'd12, 4'd12, 20);
    accept();
    run_feed(2, 1'b0);
    finish_set(2, 4'd15, 4'd0, 4'd0, 4'd0, 30);
    accept();
    chk("multi_busy_fall", 32'(busy), 0);
    chk("multi_idle_rst", 32'(eng_rst), 0);

    // Timeout: no DONE, TIMEOUT=100
    do_start(2'd0);
    run_feed(0, 1'b0);
    repeat (100) tick();
    chk("to_not_yet", 32'(res_valid), 0);
    tick();
    chk("to_valid", 32'(res_valid), 1);
    chk("to_err", 32'(res_err), 1);
    chk("to_c1x", 32'(res_c1x), 0);
    chk("to_c1y", 32'(res_c1y), 0);
    chk("to_c2x", 32'(res_c2x), 0);
    chk("to_c2y", 32'(res_c2y), 0);
    chk("to_cover", 32'(res_cover), 0);
    accept();
    chk("to_busy_fall", 32'(busy), 0);

    // DONE on the same cycle the counter reaches TIMEOUT: DONE wins
    do_start(2'd0);
    run_feed(0, 1'b0);
    repeat (100) tick();
    finish_set(0, 4'd3, 4'd3, 4'd12, 4'd12, 40);
    accept();

    // Reset in the middle of a feed
    do_start(2'd1);
    chk("mid_erst", 32'(eng_rst), 1);
    repeat (3) tick();
    chk("mid_feed_x", 32'(X), 32'(px(0, 2)));
    RST = 1'b1;
    #1;
    chk("mid_rst_busy", 32'(busy), 0);
    chk("mid_rst_x", 32'(X), 0);
    chk("mid_rst_y", 32'(Y), 0);
    chk("mid_rst_eng", 32'(eng_rst), 1);
    chk("mid_rst_valid", 32'(res_valid), 0);
    chk("mid_rst_c1x", 32'(res_c1x), 0);
    chk("mid_rst_c2y", 32'(res_c2y), 0);
    chk("mid_rst_set", 32'(res_set), 0);
    tick();
    RST = 1'b0;
    tick();
    chk("after_rst_busy", 32'(busy), 0);
    chk("after_rst_eng", 32'(eng_rst), 0);
    chk("after_rst_x", 32'(X), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
